// File: rtl/llander_thrust_ctrl.sv
// llander_thrust_ctrl: d-pad ramp / analog stick thrust source with slew-limited handoff to analog
module llander_thrust_ctrl #(
  parameter int TICK_DIV     = 98_425,
  parameter int THRUST_MAX   = 254,
  parameter int HANDOFF_STEP = 4
) (
  input  logic       clk_25,
  input  logic       RESET_L,
  input  logic       dpad_mode,
  input  logic       freeze,
  input  logic       thr_up,
  input  logic       thr_down,
  input  logic [7:0] analog_y,
  output logic [7:0] thrust,
  output logic       src_analog,
  output logic       handoff,
  output logic       tick
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [1:0] S_DPAD    = 2'd0;
  localparam logic [1:0] S_HANDOFF = 2'd1;
  localparam logic [1:0] S_ANALOG  = 2'd2;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_state;
  logic [7:0]    r_thrust;
  logic [7:0]    r_a_tgt;
  logic          w_tick;
  logic [8:0]    w_raw;
  logic [7:0]    w_a_tgt;
  logic [9:0]    w_d;
  logic [9:0]    w_mag;
  logic          w_near;
  logic [7:0]    w_step;
  logic [1:0]    w_state_nx;
  logic [7:0]    w_thrust_nx;
  assign w_tick  = (r_presc == PW'(TICK_DIV - 1)) && !freeze;
  // 127 - y sign-extended to 9 bits spans 0..255; only 255 needs clamping
  assign w_raw   = 9'd127 - {analog_y[7], analog_y};
  assign w_a_tgt = (w_raw > 9'(THRUST_MAX)) ? 8'(THRUST_MAX) : w_raw[7:0];
  assign w_d     = {2'b00, r_a_tgt} - {2'b00, r_thrust};
  assign w_mag   = w_d[9] ? -w_d : w_d;
  assign w_near  = w_mag <= 10'(HANDOFF_STEP);
  assign w_step  = w_near ? r_a_tgt : w_d[9] ? r_thrust - 8'(HANDOFF_STEP) : r_thrust + 8'(HANDOFF_STEP);
  // In S_DPAD the thrust register doubles as the ramp accumulator, so returning to d-pad never jumps
  always_comb begin
    w_state_nx  = r_state;
    w_thrust_nx = r_thrust;
    if (r_state == S_DPAD) begin
      if (!dpad_mode) w_state_nx = S_HANDOFF;
      else if (w_tick && thr_up && !thr_down && r_thrust < 8'(THRUST_MAX)) w_thrust_nx = r_thrust + 8'd1;
      else if (w_tick && thr_down && !thr_up && r_thrust != 8'd0) w_thrust_nx = r_thrust - 8'd1;
    end else if (dpad_mode) begin
      w_state_nx = S_DPAD;
    end else if (r_state == S_ANALOG) begin
      w_thrust_nx = r_a_tgt;
    end else if (w_tick) begin
      w_thrust_nx = w_step;
      w_state_nx  = w_near ? S_ANALOG : S_HANDOFF;
    end
  end
  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      r_presc  <= '0;
      r_state  <= S_DPAD;
      r_thrust <= 8'd0;
      r_a_tgt  <= 8'd0;
    end else begin
      r_a_tgt <= w_a_tgt;
      if (!freeze) begin
        r_presc  <= w_tick ? '0 : r_presc + 1'b1;
        r_state  <= w_state_nx;
        r_thrust <= w_thrust_nx;
      end
    end
  end
  assign thrust     = r_thrust;
  assign src_analog = r_state == S_ANALOG;
  assign handoff    = r_state == S_HANDOFF;
  assign tick       = w_tick;
endmodule

// File: tb/tb_llander_thrust_ctrl.sv
// tb_llander_thrust_ctrl: directed scenarios for the thrust sequencer with TICK_DIV=4
module tb_llander_thrust_ctrl;
  logic       clk_25 = 1'b0;
  logic       RESET_L = 1'b0;
  logic       dpad_mode = 1'b1;
  logic       freeze = 1'b0;
  logic       thr_up = 1'b0;
  logic       thr_down = 1'b0;
  logic [7:0] analog_y = 8'd0;
  logic [7:0] thrust;
  logic       src_analog;
  logic       handoff;
  logic       tick;
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  llander_thrust_ctrl #(.TICK_DIV(4), .THRUST_MAX(254), .HANDOFF_STEP(4)) dut (
    .clk_25(clk_25), .RESET_L(RESET_L), .dpad_mode(dpad_mode), .freeze(freeze),
    .thr_up(thr_up), .thr_down(thr_down), .analog_y(analog_y),
    .thrust(thrust), .src_analog(src_analog), .handoff(handoff), .tick(tick)
  );
  always #5 clk_25 = ~clk_25;
  task automatic step();
    @(negedge clk_25);
    cyc++;
  endtask
  task automatic do_reset(input logic mode, input logic [7:0] y);
    @(negedge clk_25);
    RESET_L = 1'b0;
    dpad_mode = mode;
    analog_y = y;
    freeze = 1'b0;
    thr_up = 1'b0;
    thr_down = 1'b0;
    repeat (2) @(negedge clk_25);
    RESET_L = 1'b1;
    cyc = 0;
  endtask
  task automatic test_reset();
    do_reset(1'b0, 8'h80);
    n_cmp++;
    if ({thrust, tick, handoff, src_analog} !== 11'd0) begin
      n_err++;
      $display("FAIL reset thrust=%0d tick=%0b handoff=%0b src=%0b exp all 0", thrust, tick, handoff, src_analog);
    end
    step();
    n_cmp++;
    if (handoff !== 1'b1 || thrust !== 8'd0) begin
      n_err++;
      $display("FAIL reset_to_handoff handoff=%0b thrust=%0d exp 1/0", handoff, thrust);
    end
  endtask
  task automatic test_ramp_up();
    int e;
    do_reset(1'b1, 8'h00);
    thr_up = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      step();
      e = (cyc / 4 > 254) ? 254 : cyc / 4;
      n_cmp++;
      if (thrust !== 8'(e) || tick !== (cyc % 4 == 3)) begin
        n_err++;
        $display("FAIL ramp_up cyc=%0d thrust=%0d tick=%0b exp %0d/%0b", cyc, thrust, tick, e, cyc % 4 == 3);
      end
    end
  endtask
  task automatic test_hold_and_floor();
    int e;
    do_reset(1'b1, 8'h00);
    thr_up = 1'b1;
    repeat (40) step();
    n_cmp++;
    if (thrust !== 8'd10) begin
      n_err++;
      $display("FAIL preload thrust=%0d exp 10", thrust);
    end
    thr_down = 1'b1;
    repeat (40) begin
      step();
      n_cmp++;
      if (thrust !== 8'd10) begin
        n_err++;
        $display("FAIL both_pressed cyc=%0d thrust=%0d exp 10", cyc, thrust);
      end
    end
    thr_up = 1'b0;
    repeat (60) begin
      step();
      e = 10 - (cyc - 80) / 4;
      e = e < 0 ? 0 : e;
      n_cmp++;
      if (thrust !== 8'(e)) begin
        n_err++;
        $display("FAIL floor cyc=%0d thrust=%0d exp %0d", cyc, thrust, e);
      end
    end
  endtask
  task automatic test_handoff_ramp();
    int e;
    do_reset(1'b0, 8'h80);
    repeat (260) begin
      step();
      e = cyc < 256 ? 4 * (cyc / 4) : 254;
      n_cmp++;
      if (thrust !== 8'(e) || handoff !== (cyc < 256) || src_analog !== (cyc >= 256)) begin
        n_err++;
        $display("FAIL handoff_ramp cyc=%0d thrust=%0d handoff=%0b src=%0b exp %0d", cyc, thrust, handoff, src_analog, e);
      end
    end
  endtask
  task automatic test_analog_step();
    analog_y = 8'h00;
    step();
    n_cmp++;
    if (thrust !== 8'd254) begin
      n_err++;
      $display("FAIL analog_latency thrust=%0d exp 254", thrust);
    end
    step();
    n_cmp++;
    if (thrust !== 8'd127) begin
      n_err++;
      $display("FAIL analog_mid thrust=%0d exp 127", thrust);
    end
    repeat (2) step();
    analog_y = 8'h7F;
    step();
    n_cmp++;
    if (thrust !== 8'd127) begin
      n_err++;
      $display("FAIL analog_pre thrust=%0d exp 127", thrust);
    end
    step();
    n_cmp++;
    if (thrust !== 8'd0 || src_analog !== 1'b1) begin
      n_err++;
      $display("FAIL analog_zero thrust=%0d src=%0b exp 0/1", thrust, src_analog);
    end
    dpad_mode = 1'b1;
    thr_up = 1'b1;
    step();
    n_cmp++;
    if (thrust !== 8'd0 || src_analog !== 1'b0) begin
      n_err++;
      $display("FAIL analog_to_dpad thrust=%0d src=%0b exp 0/0", thrust, src_analog);
    end
    step();
    n_cmp++;
    if (thrust !== 8'd1) begin
      n_err++;
      $display("FAIL dpad_after_analog thrust=%0d exp 1", thrust);
    end
    thr_up = 1'b0;
  endtask
  task automatic test_freeze();
    int e;
    do_reset(1'b0, 8'hB7);
    while (cyc < 103) step();
    n_cmp++;
    if (thrust !== 8'd100 || tick !== 1'b1) begin
      n_err++;
      $display("FAIL pre_freeze thrust=%0d tick=%0b exp 100/1", thrust, tick);
    end
    freeze = 1'b1;
    #1;
    n_cmp++;
    if (tick !== 1'b0) begin
      n_err++;
      $display("FAIL freeze_tick tick=%0b exp 0", tick);
    end
    repeat (20) begin
      step();
      n_cmp++;
      if (thrust !== 8'd100 || tick !== 1'b0 || handoff !== 1'b1) begin
        n_err++;
        $display("FAIL frozen cyc=%0d thrust=%0d tick=%0b handoff=%0b exp 100/0/1", cyc, thrust, tick, handoff);
      end
    end
    freeze = 1'b0;
    #1;
    n_cmp++;
    if (tick !== 1'b1) begin
      n_err++;
      $display("FAIL unfreeze_tick tick=%0b exp 1", tick);
    end
    repeat (10) begin
      step();
      e = 4 * ((cyc - 20) / 4);
      n_cmp++;
      if (thrust !== 8'(e)) begin
        n_err++;
        $display("FAIL resume cyc=%0d thrust=%0d exp %0d", cyc, thrust, e);
      end
    end
    RESET_L = 1'b0;
    #1;
    n_cmp++;
    if (thrust !== 8'd0 || handoff !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset thrust=%0d handoff=%0b exp 0/0", thrust, handoff);
    end
    step();
    RESET_L = 1'b1;
  endtask
  task automatic test_exit_on_tick();
    int e;
    do_reset(1'b0, 8'hB7);
    while (cyc < 43) step();
    n_cmp++;
    if (thrust !== 8'd40 || tick !== 1'b1) begin
      n_err++;
      $display("FAIL pre_exit thrust=%0d tick=%0b exp 40/1", thrust, tick);
    end
    dpad_mode = 1'b1;
    step();
    n_cmp++;
    if (thrust !== 8'd40 || handoff !== 1'b0) begin
      n_err++;
      $display("FAIL exit_no_step thrust=%0d handoff=%0b exp 40/0", thrust, handoff);
    end
    thr_up = 1'b1;
    while (cyc < 48) step();
    n_cmp++;
    if (thrust !== 8'd41) begin
      n_err++;
      $display("FAIL acc_from_thrust thrust=%0d exp 41", thrust);
    end
    thr_up = 1'b0;
    dpad_mode = 1'b0;
    analog_y = 8'h7F;
    while (cyc < 96) begin
      step();
      e = cyc >= 92 ? 0 : 41 - 4 * ((cyc - 48) / 4);
      n_cmp++;
      if (thrust !== 8'(e) || src_analog !== (cyc >= 92)) begin
        n_err++;
        $display("FAIL handoff_down cyc=%0d thrust=%0d src=%0b exp %0d", cyc, thrust, src_analog, e);
      end
    end
  endtask
  initial begin
    test_reset();
    test_ramp_up();
    test_hold_and_floor();
    test_handoff_ramp();
    test_analog_step();
    test_freeze();
    test_exit_on_tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
